// File: rtl/queue_dispatcher.sv
// ============================================================================
// queue_dispatcher : ticket FIFO feeding the lowest-indexed idle counter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module queue_dispatcher #(
  parameter int TIME_W = 4,
  parameter int N_CNT  = 3,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arr,
  input  logic [TIME_W-1:0] arr_t,
  output logic              arr_ok,
  output logic [3:0]        arr_num,
  output logic              arr_rej,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  q_cnt,
  input  logic [N_CNT-1:0]  busy,
  output logic [N_CNT-1:0]  ld,
  output logic [3:0]        dn,
  output logic [TIME_W-1:0] dt
);

  localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(DEPTH);
  localparam logic [3:0]       C_TKT_MAX = 4'd15;

  logic [3:0]        r_mem_num [DEPTH];
  logic [TIME_W-1:0] r_mem_t   [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_tkt;

  logic              w_accept;
  logic              w_reject;
  logic              w_pop;
  logic [N_CNT-1:0]  w_avail;
  logic [N_CNT-1:0]  w_sel;

  assign full  = (r_cnt == C_DEPTH);
  assign empty = (r_cnt == '0);
  assign q_cnt = r_cnt;

  // Acceptance looks only at the registered full flag; a same-cycle pop does not help.
  assign w_accept = arr & ~full & (arr_t != '0);
  assign w_reject = arr & ~w_accept;

  // A counter pulsed last edge has not raised busy yet, so mask it via ld.
  assign w_avail = ~busy & ~ld;
  assign w_pop   = ~empty & (|w_avail);
  assign w_sel   = w_avail & (~w_avail + N_CNT'(1));

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_num[r_wr_ptr] <= r_tkt;
      r_mem_t[r_wr_ptr]   <= arr_t;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_tkt    <= 4'd1;
      arr_ok   <= 1'b0;
      arr_num  <= '0;
      arr_rej  <= 1'b0;
      ld       <= '0;
      dn       <= '0;
      dt       <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_tkt    <= (r_tkt == C_TKT_MAX) ? 4'd1 : r_tkt + 4'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      arr_ok  <= w_accept;
      arr_num <= w_accept ? r_tkt : 4'd0;
      arr_rej <= w_reject;
      ld      <= w_pop ? w_sel : '0;
      dn      <= w_pop ? r_mem_num[r_rd_ptr] : 4'd0;
      dt      <= w_pop ? r_mem_t[r_rd_ptr] : '0;
    end
  end

endmodule

`default_nettype wire

// File: doc/queue_dispatcher.md
Name: queue_dispatcher

Overview:
- Upstream stage of the per-counter service blocks: a ticket queue and dispatcher.
- Accepts customer arrivals, each with a service time, and assigns each a ticket number 1..15.
- Holds waiting customers in a FIFO.
- Issues a one-cycle load pulse plus {number, time} to the lowest-indexed idle counter.
- Sits between the arrival/keypad logic and an array of N_CNT counter instances that share the dn/dt bus.

Parameters:
TIME_W  4  service-time width; must match counter TIME_W
N_CNT  3  number of downstream counters (1..8)
DEPTH  8  queue entries, power of 2 (2..16)
CNT_W  4  width of q_cnt; must satisfy 2^CNT_W > DEPTH

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
arr  in  1  arrival strobe, one cycle per customer
arr_t  in  TIME_W  service time of the arriving customer
arr_ok  out  1  registered; high one cycle after an accepted arrival
arr_num  out  4  ticket number given to that arrival; valid while arr_ok=1, else 0
arr_rej  out  1  registered; high one cycle after a rejected arrival
full  out  1  queue holds DEPTH entries
empty  out  1  queue holds 0 entries
q_cnt  out  CNT_W  number of waiting entries
busy  in  N_CNT  busy flags from the counters; bit i = counter i
ld  out  N_CNT  registered one-hot load pulses to the counters
dn  out  4  registered ticket number on the shared bus; 0 when no ld
dt  out  TIME_W  registered service time on the shared bus; 0 when no ld

Behaviour:
Reset (async, rst_n=0):
- All outputs are 0 except empty=1.
- Queue pointers are 0.
- Next-ticket register is 1.
- Reset mid-operation discards all queued entries. Any ld pulse in flight is lost (ld=0 immediately).

Arrival acceptance (sampled at the clk edge):
- arr=1, full=0, arr_t!=0: write {tkt, arr_t} at the tail and increment tkt. Next cycle arr_ok=1 and arr_num=the written tkt.
- arr=1 with full=1 or arr_t==0: nothing is written; next cycle arr_rej=1 and arr_num=0.
- Acceptance uses the current full flag only. A same-cycle dispatch does not free a slot for that arrival.
- Ticket sequence is 1,2,…,15,1,… and never 0, because 0 means idle at the counters.

Dispatch selection (combinational within a cycle, result registered):
- avail = ~busy & ~ld. A counter pulsed this cycle is treated as taken because its busy only rises next cycle.
- If empty=0 and avail!=0: pick the lowest index i with avail[i]=1.
- At the next edge: ld<=onehot(i), dn/dt<=head entry, and the head pops.
- Otherwise at the next edge: ld<=0, dn<=0, dt<=0.
- At most one dispatch per cycle. ld is never high for 2 consecutive cycles on the same bit.

Occupancy:
- Simultaneous accept and pop: q_cnt unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- full = (q_cnt==DEPTH); empty = (q_cnt==0); both are derived from the registered count.

Latency:
- arr in cycle 0 → entry stored at the end of cycle 0.
- empty=0 in cycle 1 → ld/dn/dt high in cycle 2 → counter busy=1 in cycle 3.
- There is no bypass from arr to ld.

Counter release:
- A counter whose busy falls in cycle c is selectable in cycle c, so its ld is high in cycle c+1.

Order and fairness:
- Strict FIFO order of customers.
- Fixed priority among counters: lowest index first.

Test Plan:
1. Reset, then arr with arr_t=3 while all busy=0 → cycle 1: arr_ok=1, arr_num=1; cycle 2: ld=3'b001, dn=1, dt=3; cycle 3: ld=0, dn=0, empty=1.
2. Hold busy=3'b111 and issue 9 arrivals (DEPTH=8) → tickets 1..8 accepted, full=1, q_cnt=8, 9th gives arr_rej=1; then release busy[1] → ld=3'b010, dn=1; q_cnt=7.
3. Issue arrivals back-to-back with busy driven from 3 real counter instances → ld goes 001, 010, 100 in consecutive cycles; no counter receives two ld pulses before its busy falls.
4. Accept 16 arrivals with dispatch keeping pace → ticket numbers run 1..15 then 1; dn is never 0 while any ld bit is 1.
5. arr with arr_t=0 → arr_rej=1, q_cnt unchanged; arr while full in the same cycle as a pop → rejected, q_cnt=DEPTH-1 afterwards.
6. Assert rst_n=0 with 4 entries queued and ld high → ld, dn, dt, and q_cnt go 0 immediately and empty=1; after release the first new arrival gets arr_num=1.
